// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: MDU operation codes, default latencies and FSM states shared by controller and datapath.
package mdu_unit_pkg;
    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;
    typedef enum logic {IDLE, RUN} mduState_e;
endpackage

// File: rtl/mdu_unit_if.sv
// mdu_unit_if: E-stage issue bus into the MDU and its HI/LO/busy results.
interface mdu_unit_if;
    logic        MduStart;
    logic [3:0]  MDUType;
    logic        Req;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MduOut;
    modport master (output MduStart, MDUType, Req, A, B, input Busy, HI, LO, MduOut);
    modport slave  (input MduStart, MDUType, Req, A, B, output Busy, HI, LO, MduOut);
endinterface

// File: rtl/mdu_unit_arith.sv
// mdu_arith: combinational 32x32 multiply and divide producing the 64-bit HI/LO result.
module mdu_arith (
    input  logic        isSigned,
    input  logic        isDiv,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div_zero
);
    logic        aNeg, bNeg;
    logic [31:0] aMag, bMag, bSafe, quo, rem;
    logic [63:0] prod;
    always_comb begin
        aNeg = isSigned && a[31];
        bNeg = isSigned && b[31];
        prod = {{32{aNeg}}, a} * {{32{bNeg}}, b};
        aMag = aNeg ? -a : a;
        bMag = bNeg ? -b : b;
        div_zero = isDiv && (b == 32'd0);
        // divisor forced nonzero so the unused quotient never goes X on divide-by-zero
        bSafe = (b == 32'd0) ? 32'd1 : bMag;
        quo = aMag / bSafe;
        rem = aMag % bSafe;
        hi_next = isDiv ? (aNeg ? -rem : rem) : prod[63:32];
        lo_next = isDiv ? ((aNeg ^ bNeg) ? -quo : quo) : prod[31:0];
    end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: HI/LO registers plus fixed-latency busy FSM for mult/div/mthi/mtlo/mfhi/mflo.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input logic       clk,
    input logic       reset_n,
    mdu_unit_if.slave bus
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    mduState_e     state, stateNext;
    logic [CW-1:0] count, countNext;
    logic [31:0]   hiReg, loReg, hiRegNext, loRegNext;
    logic [31:0]   pendHi, pendLo, pendHiNext, pendLoNext;
    logic [31:0]   hi_next, lo_next;
    logic          pendEn, pendEnNext, div_zero, accept, isMul, isDiv, isSigned;

    assign isMul    = (bus.MDUType == MDU_MULT) || (bus.MDUType == MDU_MULTU);
    assign isDiv    = (bus.MDUType == MDU_DIV) || (bus.MDUType == MDU_DIVU);
    assign isSigned = (bus.MDUType == MDU_MULT) || (bus.MDUType == MDU_DIV);
    assign accept   = bus.MduStart && !bus.Req && (state == IDLE);

    mdu_arith uArith (
        .isSigned (isSigned),
        .isDiv    (isDiv),
        .a        (bus.A),
        .b        (bus.B),
        .hi_next  (hi_next),
        .lo_next  (lo_next),
        .div_zero (div_zero)
    );

    always_comb begin
        stateNext  = state;
        countNext  = count;
        hiRegNext  = hiReg;
        loRegNext  = loReg;
        pendHiNext = pendHi;
        pendLoNext = pendLo;
        pendEnNext = pendEn;
        if (state == IDLE) begin
            if (accept && (isMul || isDiv)) begin
                stateNext  = RUN;
                countNext  = isMul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                pendHiNext = hi_next;
                pendLoNext = lo_next;
                pendEnNext = !div_zero;
            end
            hiRegNext = (accept && bus.MDUType == MDU_MTHI) ? bus.A : hiReg;
            loRegNext = (accept && bus.MDUType == MDU_MTLO) ? bus.A : loReg;
        end else begin
            // Req is deliberately ignored here: the running op belongs to an already-committed instruction
            countNext = count - CW'(1);
            if (count == CW'(1)) begin
                stateNext = IDLE;
                hiRegNext = pendEn ? pendHi : hiReg;
                loRegNext = pendEn ? pendLo : loReg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            hiReg  <= '0;
            loReg  <= '0;
            pendHi <= '0;
            pendLo <= '0;
            pendEn <= 1'b0;
        end else begin
            state  <= stateNext;
            count  <= countNext;
            hiReg  <= hiRegNext;
            loReg  <= loRegNext;
            pendHi <= pendHiNext;
            pendLo <= pendLoNext;
            pendEn <= pendEnNext;
        end
    end

    assign bus.Busy   = (state == RUN);
    assign bus.HI     = hiReg;
    assign bus.LO     = loReg;
    assign bus.MduOut = (bus.MDUType == MDU_MFHI) ? hiReg : (bus.MDUType == MDU_MFLO) ? loReg : 32'd0;
endmodule
